// File: rtl/led_scan_pkg.sv
// Shared constants and scan-state type for the LED column scanner.
package led_scan_pkg;

    localparam int COLUMN_WIDTH      = 4;
    localparam int DEF_NUM_ROWS      = 10;
    localparam int DEF_DWELL_CYCLES  = 5000;
    localparam int DEF_BLANK_CYCLES  = 64;
    localparam int DEF_STABLE_CYCLES = 4;

    typedef enum logic {
        SCAN_BLANK = 1'b0,
        SCAN_DRIVE = 1'b1
    } scan_state_e;

endpackage

// File: rtl/column_sync_filter.sv
// Two-flop synchroniser on the JTAG column pattern followed by a stability filter
// that only accepts a value after it has been seen unchanged for STABLE_CYCLES samples.
module column_sync_filter
    import led_scan_pkg::*;
#(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [COLUMN_WIDTH-1:0] columns_async,
    output logic [COLUMN_WIDTH-1:0] filtered
);

    localparam int SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [SW-1:0] STABLE_MAX = SW'(STABLE_CYCLES - 1);

    logic [COLUMN_WIDTH-1:0] sync0_q, sync1_q;
    logic [COLUMN_WIDTH-1:0] candidate_q, candidate_d;
    logic [COLUMN_WIDTH-1:0] filtered_q, filtered_d;
    logic [SW-1:0]           stable_cnt_q, stable_cnt_d;

    always_comb begin
        candidate_d  = candidate_q;
        stable_cnt_d = stable_cnt_q;
        filtered_d   = filtered_q;
        if (sync1_q != candidate_q) begin
            candidate_d  = sync1_q;
            stable_cnt_d = '0;
        end else if (stable_cnt_q != STABLE_MAX) begin
            stable_cnt_d = stable_cnt_q + 1'b1;
        end
        if (stable_cnt_q == STABLE_MAX) begin
            filtered_d = candidate_q;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync0_q      <= '0;
            sync1_q      <= '0;
            candidate_q  <= '0;
            stable_cnt_q <= '0;
            filtered_q   <= '0;
        end else begin
            sync0_q      <= columns_async;
            sync1_q      <= sync0_q;
            candidate_q  <= candidate_d;
            stable_cnt_q <= stable_cnt_d;
            filtered_q   <= filtered_d;
        end
    end

    assign filtered = filtered_q;

endmodule

// File: rtl/led_column_scanner.sv
// Row-multiplexed LED matrix driver: per-row slots with a blanked lead-in, column
// pattern only refreshed on slot boundaries so a row never shows a mixed value.
module led_column_scanner
    import led_scan_pkg::*;
#(
    parameter int NUM_ROWS      = DEF_NUM_ROWS,
    parameter int DWELL_CYCLES  = DEF_DWELL_CYCLES,
    parameter int BLANK_CYCLES  = DEF_BLANK_CYCLES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [COLUMN_WIDTH-1:0]     columns_async,
    output logic [NUM_ROWS-1:0]         row_n,
    output logic [COLUMN_WIDTH-1:0]     column_out,
    output logic [$clog2(NUM_ROWS)-1:0] row_index,
    output logic                        frame_start,
    output logic                        value_updated
);

    localparam int ROW_W = $clog2(NUM_ROWS);
    localparam int CNT_W = $clog2(DWELL_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(NUM_ROWS - 1);

    logic [COLUMN_WIDTH-1:0] filtered;

    column_sync_filter #(.STABLE_CYCLES(STABLE_CYCLES)) u_filter (
        .clock         (clock),
        .reset         (reset),
        .columns_async (columns_async),
        .filtered      (filtered)
    );

    logic                    run_q, run_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ROW_W-1:0]        row_q, row_d;
    logic [COLUMN_WIDTH-1:0] display_q, display_d;
    logic [NUM_ROWS-1:0]     row_n_q, row_n_d;
    logic [COLUMN_WIDTH-1:0] column_out_q, column_out_d;
    logic                    frame_start_q, frame_start_d;
    logic                    value_updated_q, value_updated_d;
    logic                    slot_start;
    scan_state_e             slot_state;

    // run_q marks that the previous cycle was already scanning, so the first
    // enabled cycle always lands on cnt=0 / row 0.
    always_comb begin
        run_d = enable;
        cnt_d = '0;
        row_d = '0;
        if (enable && run_q) begin
            if (cnt_q == CNT_LAST) begin
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
                row_d = row_q;
            end
        end

        slot_start      = run_d && (cnt_d == '0);
        display_d       = slot_start ? filtered : display_q;
        value_updated_d = slot_start && (filtered != display_q);
        frame_start_d   = slot_start && (row_d == '0);

        slot_state   = (run_d && (cnt_d >= CNT_BLANK)) ? SCAN_DRIVE : SCAN_BLANK;
        row_n_d      = '1;
        column_out_d = '0;
        if (slot_state == SCAN_DRIVE) begin
            row_n_d      = ~(NUM_ROWS'(1) << row_d);
            column_out_d = display_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            run_q           <= 1'b0;
            cnt_q           <= '0;
            row_q           <= '0;
            display_q       <= '0;
            row_n_q         <= '1;
            column_out_q    <= '0;
            frame_start_q   <= 1'b0;
            value_updated_q <= 1'b0;
        end else begin
            run_q           <= run_d;
            cnt_q           <= cnt_d;
            row_q           <= row_d;
            display_q       <= display_d;
            row_n_q         <= row_n_d;
            column_out_q    <= column_out_d;
            frame_start_q   <= frame_start_d;
            value_updated_q <= value_updated_d;
        end
    end

    assign row_n         = row_n_q;
    assign column_out    = column_out_q;
    assign row_index     = row_q;
    assign frame_start   = frame_start_q;
    assign value_updated = value_updated_q;

endmodule

// File: tb/tb_led_column_scanner.sv
// Scoreboard bench for led_column_scanner with a small matrix (3 rows, 8-cycle slots).
module tb_led_column_scanner;

    localparam int NR = 3;
    localparam int DW = 8;
    localparam int BL = 2;
    localparam int ST = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic [3:0]    columns_async = 4'h0;
    logic [NR-1:0] row_n;
    logic [3:0]    column_out;
    logic [1:0]    row_index;
    logic          frame_start;
    logic          value_updated;

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;

    typedef struct {
        int         stamp;
        logic [3:0] pat;
    } upd_t;

    upd_t upd_q[$];
    int   frame_q[$];

    led_column_scanner #(
        .NUM_ROWS      (NR),
        .DWELL_CYCLES  (DW),
        .BLANK_CYCLES  (BL),
        .STABLE_CYCLES (ST)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .columns_async (columns_async),
        .row_n         (row_n),
        .column_out    (column_out),
        .row_index     (row_index),
        .frame_start   (frame_start),
        .value_updated (value_updated)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, got, exp, cyc);
    endtask

    task automatic at(input int n);
        while (cyc < n) @(negedge clock);
    endtask

    // Monitor: frame_start and value_updated pulses are matched against queued
    // expectations; the pattern of each update is checked on its first driven cycle.
    initial begin : monitor
        upd_t       e;
        bit         pend;
        logic [3:0] pend_pat;
        pend = 1'b0;
        pend_pat = 4'h0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                if (frame_start) begin
                    if (frame_q.size() == 0) chk("frame_start_unexpected", frame_start, 0);
                    else chk("frame_start_cycle", cyc, frame_q.pop_front());
                end
                if (value_updated) begin
                    if (upd_q.size() == 0) chk("value_updated_unexpected", value_updated, 0);
                    else begin
                        e = upd_q.pop_front();
                        chk("value_updated_cycle", cyc, e.stamp);
                        pend = 1'b1;
                        pend_pat = e.pat;
                    end
                end else if (pend && row_n != 3'b111) begin
                    chk("updated_pattern", column_out, pend_pat);
                    pend = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not complete at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin : stimulus
        logic [3:0] disp [15] = '{4'h0, 4'hA, 4'hA, 4'hA, 4'hA, 4'hA, 4'h3, 4'h3,
                                  4'h3, 4'hC, 4'hC, 4'h0, 4'h0, 4'h0, 4'h0};
        int         ev_k [5] = '{39, 58, 79, 89, 92};
        logic [3:0] ev_v [5] = '{4'h3, 4'hC, 4'h0, 4'h5, 4'h0};
        logic [2:0] one;
        logic [2:0] exp_rn;
        int t0, t1, s, i;

        one = 3'b001;

        at(2);
        chk("rst_row_n", row_n, 3'b111);
        chk("rst_column_out", column_out, 0);
        chk("rst_row_index", row_index, 0);
        chk("rst_frame_start", frame_start, 0);
        chk("rst_value_updated", value_updated, 0);
        reset = 1'b0;

        at(4);
        chk("idle_row_n", row_n, 3'b111);
        chk("idle_column_out", column_out, 0);
        chk("idle_row_index", row_index, 0);

        at(5);
        t0 = 6;
        columns_async = 4'hA;
        enable = 1'b1;
        frame_q.push_back(t0);
        frame_q.push_back(t0 + 24);
        frame_q.push_back(t0 + 48);
        frame_q.push_back(t0 + 72);
        frame_q.push_back(t0 + 96);
        frame_q.push_back(t0 + 121);
        upd_q.push_back('{t0 + 8,  4'hA});
        upd_q.push_back('{t0 + 48, 4'h3});
        upd_q.push_back('{t0 + 72, 4'hC});
        upd_q.push_back('{t0 + 88, 4'h0});

        for (int k = 0; k <= 115; k++) begin
            s = k / DW;
            i = k % DW;
            at(t0 + k);
            exp_rn = (i < BL) ? 3'b111 : ~(one << (s % NR));
            chk("scan_row_index", row_index, s % NR);
            chk("scan_row_n", row_n, exp_rn);
            chk("scan_column_out", column_out, (i < BL) ? 4'h0 : disp[s]);
            for (int j = 0; j < 5; j++) if (k == ev_k[j]) columns_async = ev_v[j];
            if (k == 115) enable = 1'b0;
        end

        for (int k = 116; k <= 120; k++) begin
            at(t0 + k);
            chk("dis_row_n", row_n, 3'b111);
            chk("dis_column_out", column_out, 0);
            chk("dis_row_index", row_index, 0);
        end
        enable = 1'b1;

        t1 = t0 + 121;
        for (int k = 0; k < DW; k++) begin
            at(t1 + k);
            chk("restart_row_index", row_index, 0);
            chk("restart_row_n", row_n, (k < BL) ? 3'b111 : 3'b110);
            chk("restart_column_out", column_out, 0);
        end

        at(t1 + 11);
        chk("pre_reset_row_index", row_index, 1);
        chk("pre_reset_row_n", row_n, 3'b101);
        #2;
        reset = 1'b1;
        enable = 1'b0;
        #1;
        chk("async_rst_row_n", row_n, 3'b111);
        chk("async_rst_column_out", column_out, 0);
        chk("async_rst_row_index", row_index, 0);

        at(t1 + 14);
        reset = 1'b0;
        at(t1 + 16);
        chk("post_rst_row_n", row_n, 3'b111);
        chk("post_rst_frame_start", frame_start, 0);
        chk("frame_queue_drained", frame_q.size(), 0);
        chk("update_queue_drained", upd_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
